mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one memory port between the CPU instruction bus (I) and data bus (D).
- Used when the processor runs against a unified instruction/data memory instead of split memories.
- Sits between the CPU bus outputs and the memory/bus interconnect.
- Data side has priority, with a bounded-starvation guarantee for the instruction side; one transaction in flight at a time.

Parameters:
- READ_LAT, 1: memory read latency in cycles, counted from the issue clock edge to iMReadData being valid; legal range 1..7.
- MAX_STREAK, 4: maximum consecutive D grants allowed while an I request is pending; legal range 1..15.

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iIReq  in  1  instruction-side request.
- iIWrite  in  1  1 = write, 0 = read.
- iIByteEnable  in  4  byte lanes.
- iIAddress  in  32  byte address.
- iIWriteData  in  32  write data.
- oIReadData  out  32  registered read data.
- oIReady  out  1  one-cycle completion pulse.
- iDReq, iDWrite, iDByteEnable, iDAddress, iDWriteData, oDReadData, oDReady: same widths and meaning as the I side, for the data side.
- oMReadEnable  out  1  memory read strobe.
- oMWriteEnable  out  1  memory write strobe.
- oMByteEnable  out  4  memory byte lanes.
- oMAddress  out  32  memory address.
- oMWriteData  out  32  memory write data.
- iMReadData  in  32  memory read data.
- oDGrantCount  out  32  D grant count (perf counter).
- oIGrantCount  out  32  I grant count (perf counter).
- oStallCycles  out  32  stall cycle count (perf counter).

Behaviour:
- Reset (iRST=0, asynchronous):
  - State goes to IDLE; the in-flight transaction is dropped with no ready pulse.
  - All outputs are 0, including both ReadData registers and the streak counter.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select a winner, latch its Write/ByteEnable/Address/WriteData, go to ISSUE.
- Arbitration, evaluated in IDLE only:
  - Only one side requesting: that side wins.
  - Both requesting: D wins unless streak == MAX_STREAK, in which case I wins.
- Streak counter:
  - +1 on each D grant made while iIReq=1.
  - Cleared on any I grant.
  - Cleared on a D grant made while iIReq=0.
  - Saturates at MAX_STREAK.
- ISSUE (exactly 1 cycle):
  - oM* driven from the latched values; exactly one of oMReadEnable/oMWriteEnable is 1.
  - Write: winner's Ready = 1 this cycle; next state IDLE.
  - Read: next state WAIT; latency counter loaded with READ_LAT-1.
- WAIT:
  - oM enables = 0; oMAddress holds the latched address.
  - Counter decrements each cycle.
  - When counter == 0: capture iMReadData into the winner's ReadData register; next state RESP.
- RESP (1 cycle): winner's Ready = 1; next state IDLE.
- Latency, with the request sampled in IDLE at cycle N:
  - Write Ready in cycle N+1.
  - Read Ready in cycle N+2+READ_LAT.
  - Minimum spacing between grants: write 2 cycles, read READ_LAT+3 cycles.
- Handshake:
  - Requester holds Req and payload until its Ready pulse.
  - Payload changes after the grant are ignored.
  - Req dropped mid-transaction: the transaction still completes and Ready still pulses.
  - Req still high in the IDLE cycle after Ready is treated as a new request.
- ReadData registers:
  - Each holds its value until the next read completion on the same side.
  - Never disturbed by the other side or by writes.
- Only the granted side's Ready can be 1; oIReady and oDReady are never both 1.
- oMByteEnable, oMWriteData and oMAddress are 0 in IDLE.

Optional Feature:
- Macro: MEMARB_PERF_COUNTERS_EN.
- Defined:
  - oDGrantCount and oIGrantCount increment on each grant.
  - oStallCycles increments each cycle in which at least one Req=1 and neither Ready=1.
  - All three are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: counter logic absent; the three ports are tied to 0.

Test Plan:
- Reset: iRST=0 mid-WAIT of a D read -> all outputs 0 immediately; no oDReady; after release, state is IDLE; a new I read at addr 0x00400000 completes normally.
- Single read: READ_LAT=1, D read addr 0x10010004 at cycle 0, memory returns 0xDEADBEEF -> oMReadEnable=1 in cycle 1 only; oDReady and oDReadData=0xDEADBEEF in cycle 3.
- Write: I write addr 0x10010000, data 0x12345678, BE=4'b0011 -> oMWriteEnable=1 with those values in cycle 1; oIReady in cycle 1; next grant possible from cycle 2.
- Contention and starvation: iDReq and iIReq held continuously, MAX_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; Ready pulses never overlap.
- Request drop: iDReq deasserted in WAIT -> oDReady still pulses in RESP; no extra grant follows.
- Perf counters (macro defined): 3 D grants + 2 I grants under contention -> oDGrantCount=3, oIGrantCount=2, and oStallCycles equals the cycles counted by a bench model.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Lets the CPU instruction bus (I) and data bus (D) share one memory port, for
// a processor running against a unified instruction/data memory. One
// transaction is in flight at a time. The data side normally wins, but the
// instruction side cannot be starved for more than MAX_STREAK consecutive D
// grants.
//
// Parameters:
//   READ_LAT   memory read latency (1..7), counted from the issue clock edge
//              to iMReadData being valid
//   MAX_STREAK maximum consecutive D grants while I is waiting (1..15)
//
// Ports:
//   iCLK, iRST              clock (rising edge), async active-low reset
//   iIReq .. iIWriteData    instruction-side request and payload
//   oIReadData, oIReady     instruction-side read data register, done pulse
//   iDReq .. iDWriteData    data-side request and payload
//   oDReadData, oDReady     data-side read data register, done pulse
//   oMReadEnable/oMWriteEnable/oMByteEnable/oMAddress/oMWriteData
//                           memory command, valid in the ISSUE cycle
//   iMReadData              memory read data
//   oDGrantCount, oIGrantCount, oStallCycles
//                           performance counters (tied to 0 unless the macro
//                           MEMARB_PERF_COUNTERS_EN is defined)
//   oFsmState               current FSM state (debug view: 0 IDLE, 1 ISSUE,
//                           2 WAIT, 3 RESP)
//
// Handshake: a requester raises Req with its payload and holds both until
// its Ready pulses for one cycle. The payload is latched when the grant is
// made in IDLE, so later payload changes are ignored; dropping Req after the
// grant does not cancel the transaction. A Req still high in the IDLE cycle
// after Ready counts as a new request.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int READ_LAT   = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic        iIWrite,
    input  logic [3:0]  iIByteEnable,
    input  logic [31:0] iIAddress,
    input  logic [31:0] iIWriteData,
    output logic [31:0] oIReadData,
    output logic        oIReady,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [3:0]  iDByteEnable,
    input  logic [31:0] iDAddress,
    input  logic [31:0] iDWriteData,
    output logic [31:0] oDReadData,
    output logic        oDReady,
    output logic        oMReadEnable,
    output logic        oMWriteEnable,
    output logic [3:0]  oMByteEnable,
    output logic [31:0] oMAddress,
    output logic [31:0] oMWriteData,
    input  logic [31:0] iMReadData,
    output logic [31:0] oDGrantCount,
    output logic [31:0] oIGrantCount,
    output logic [31:0] oStallCycles,
    output logic [1:0]  oFsmState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_LOAD   = 3'(READ_LAT - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    state_t      state, state_nxt;
    logic        sel_d_q;      // 1: current transaction belongs to D
    logic        wr_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [2:0]  lat_q;
    logic [3:0]  streak_q;
    logic [31:0] ird_q;
    logic [31:0] drd_q;

    logic any_req;
    logic take;                // a grant is made at the end of this cycle
    logic grant_d;             // winner if a grant is made
    logic done;                // the granted side's Ready is high this cycle

    assign any_req = iIReq | iDReq;
    assign take    = (state == IDLE) && any_req;
    // I only wins a contested grant once D has used up its streak allowance.
    assign grant_d = iDReq && !(iIReq && (streak_q == STREAK_MAX));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = wr_q ? IDLE : WAIT;
            WAIT:    if (lat_q == 3'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state and the latched request so that
    // nothing leaks onto the memory port while the arbiter is idle.
    always_comb begin
        oMReadEnable  = 1'b0;
        oMWriteEnable = 1'b0;
        oMByteEnable  = 4'd0;
        oMAddress     = 32'd0;
        oMWriteData   = 32'd0;
        done          = 1'b0;
        case (state)
            ISSUE: begin
                oMReadEnable  = !wr_q;
                oMWriteEnable = wr_q;
                oMByteEnable  = be_q;
                oMAddress     = addr_q;
                oMWriteData   = wd_q;
                done          = wr_q;
            end
            WAIT: begin
                oMAddress = addr_q;
            end
            RESP: begin
                oMAddress = addr_q;
                done      = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign oIReady    = done && !sel_d_q;
    assign oDReady    = done && sel_d_q;
    assign oIReadData = ird_q;
    assign oDReadData = drd_q;
    assign oFsmState  = state;

    // ------------------------------------------------- request latch, streak
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            sel_d_q  <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= 4'd0;
            addr_q   <= 32'd0;
            wd_q     <= 32'd0;
            streak_q <= 4'd0;
        end else if (take) begin
            sel_d_q <= grant_d;
            wr_q    <= grant_d ? iDWrite      : iIWrite;
            be_q    <= grant_d ? iDByteEnable : iIByteEnable;
            addr_q  <= grant_d ? iDAddress    : iIAddress;
            wd_q    <= grant_d ? iDWriteData  : iIWriteData;
            // The streak only counts D grants that made a waiting I wait.
            if (grant_d && iIReq) begin
                if (streak_q != STREAK_MAX) streak_q <= streak_q + 4'd1;
            end else begin
                streak_q <= 4'd0;
            end
        end
    end

    // ------------------------------------------- read latency, read capture
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            lat_q <= 3'd0;
            ird_q <= 32'd0;
            drd_q <= 32'd0;
        end else begin
            if (state == ISSUE) begin
                lat_q <= LAT_LOAD;
            end else if (state == WAIT) begin
                if (lat_q == 3'd0) begin
                    if (sel_d_q) drd_q <= iMReadData;
                    else         ird_q <= iMReadData;
                end else begin
                    lat_q <= lat_q - 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------ performance counters
`ifdef MEMARB_PERF_COUNTERS_EN
    logic [31:0] dg_q, ig_q, stall_q;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            dg_q    <= 32'd0;
            ig_q    <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            if (take && grant_d)  dg_q <= dg_q + 32'd1;
            if (take && !grant_d) ig_q <= ig_q + 32'd1;
            // A stall is any cycle where someone is asking and nobody finishes.
            if (any_req && !done) stall_q <= stall_q + 32'd1;
        end
    end

    assign oDGrantCount = dg_q;
    assign oIGrantCount = ig_q;
    assign oStallCycles = stall_q;
`else
    assign oDGrantCount = 32'd0;
    assign oIGrantCount = 32'd0;
    assign oStallCycles = 32'd0;
`endif

endmodule
